// File: rtl/main_memory_model.sv
// Line-granular backing store behind the L2: answers each read/write request after a
// fixed latency with a single-cycle ready/hit strobe, then waits for the request to drop.
module main_memory_model #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_LINES  = 256,
  parameter int LATENCY    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
  input  logic                             mem_read,
  input  logic                             mem_write,
  output logic                             mem_ready,
  output logic                             mem_hit,
  output logic                             busy
);

  localparam int OFF_W  = $clog2(BLOCK_SIZE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LINE_W = BLOCK_SIZE * DATA_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                is_write_q, is_write_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                mem_wr_en;
  logic                req;
  logic                addr_unused;
  logic [LINE_W-1:0]   mem_q [NUM_LINES];

  assign req         = mem_read | mem_write;
  assign addr_unused = ^mem_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      is_write_q <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      is_write_q <= is_write_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
    end
  end

  // Reset reloads the ramp pattern, so an in-flight write is simply lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        for (int j = 0; j < BLOCK_SIZE; j++) begin
          mem_q[i][j*DATA_WIDTH +: DATA_WIDTH] <= DATA_WIDTH'(i * BLOCK_SIZE + j);
        end
      end
    end else if (mem_wr_en) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req) state_d = ST_WAIT;
      ST_WAIT:  if (cnt_q == 8'd0) state_d = ST_RESP;
      ST_RESP:  state_d = req ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (!req) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Write wins when both request levels are high; inputs are only looked at in IDLE.
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    is_write_d = is_write_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    mem_wr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d      = mem_addr[OFF_W +: IDX_W];
          is_write_d = mem_write;
          cnt_d      = 8'(LATENCY - 1);
          if (mem_write) wdata_d = mem_data_in;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          ready_d = 1'b1;
          if (is_write_q) mem_wr_en = 1'b1;
          else            rdata_d   = mem_q[idx_q];
        end
      end
      default: ;
    endcase
  end

  assign mem_ready    = ready_q;
  assign mem_hit      = ready_q;
  assign mem_data_out = rdata_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
